// File: rtl/ram_2x2_bit.sv
// Tiny register file: DEPTH x DATA_W flops, one synchronous write port, two asynchronous read ports.
// Latency: write lands on the rising edge; reads are combinational. Optional WRITE_BYPASS_EN forwards write data.
// Backpressure: none, every write and read is accepted in its cycle.
module ram_2x2_bit #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Write_Address,
    input  logic              Write_Enable,
    input  logic [ADDR_W-1:0] Read_Address_1,
    input  logic [ADDR_W-1:0] Read_Address_2,
    output logic [DATA_W-1:0] Read_Data_1,
    output logic [DATA_W-1:0] Read_Data_2
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;

    // Addresses at or beyond DEPTH exist only for non-power-of-two depths.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_V);
    endfunction

    assign wr_ok = Write_Enable && in_range(Write_Address);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[Write_Address[IDX_W-1:0]] <= Write_Data;
        end
    end

    always_comb begin
        Read_Data_1 = '0;
        if (in_range(Read_Address_1)) begin
            Read_Data_1 = mem[Read_Address_1[IDX_W-1:0]];
        end
`ifdef WRITE_BYPASS_EN
        if (reset && wr_ok && (Read_Address_1 == Write_Address)) begin
            Read_Data_1 = Write_Data;
        end
`endif
    end

    always_comb begin
        Read_Data_2 = '0;
        if (in_range(Read_Address_2)) begin
            Read_Data_2 = mem[Read_Address_2[IDX_W-1:0]];
        end
`ifdef WRITE_BYPASS_EN
        if (reset && wr_ok && (Read_Address_2 == Write_Address)) begin
            Read_Data_2 = Write_Data;
        end
`endif
    end

endmodule

// File: tb/tb_ram_2x2_bit.sv
// Bench for ram_2x2_bit: directed plan steps plus random traffic, scored against an array model.
module tb_ram_2x2_bit;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 2;
    localparam int ADDR_W = 1;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] Write_Data;
    logic [ADDR_W-1:0] Write_Address;
    logic              Write_Enable;
    logic [ADDR_W-1:0] Read_Address_1;
    logic [ADDR_W-1:0] Read_Address_2;
    logic [DATA_W-1:0] Read_Data_1;
    logic [DATA_W-1:0] Read_Data_2;

    ram_2x2_bit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .Write_Data     (Write_Data),
        .Write_Address  (Write_Address),
        .Write_Enable   (Write_Enable),
        .Read_Address_1 (Read_Address_1),
        .Read_Address_2 (Read_Address_2),
        .Read_Data_1    (Read_Data_1),
        .Read_Data_2    (Read_Data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: plain word array plus the write that will land at the next edge.
    int model [DEPTH];
    bit rst_now;
    bit prev_we;
    int prev_wa;
    int prev_wd;

    function automatic int model_read(input int ra, input bit we, input int wa, input int wd);
        int v;
        v = (ra < DEPTH) ? model[ra] : 0;
`ifdef WRITE_BYPASS_EN
        if (rst_now && we && wa == ra && wa < DEPTH) v = wd;
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
    endtask

    // One clock cycle of stimulus; the expected pre-edge read values are queued for the monitor.
    task automatic cycle(input bit we, input int wa, input int wd, input int ra1, input int ra2,
                         input bit rst_v, input bit mid_rst, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_we && rst_now && prev_wa < DEPTH) model[prev_wa] = prev_wd;
        rst_now = rst_v;
        reset   = rst_v;
        if (!rst_v) model_clear();
        Write_Enable   = we;
        Write_Address  = ADDR_W'(wa);
        Write_Data     = DATA_W'(wd);
        Read_Address_1 = ADDR_W'(ra1);
        Read_Address_2 = ADDR_W'(ra2);
        prev_we = we;
        prev_wa = wa;
        prev_wd = wd;
        if (mid_rst) begin
            #1;
            reset   = 1'b0;
            rst_now = 1'b0;
            model_clear();
        end
        e.tag = tag;
        e.rd1 = DATA_W'(model_read(ra1, we, wa, wd));
        e.rd2 = DATA_W'(model_read(ra2, we, wa, wd));
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are settled by the falling edge, well away from the writing edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (Read_Data_1 !== e.rd1) begin
                bad++;
                $display("FAIL %s rd1: got %b expected %b", e.tag, Read_Data_1, e.rd1);
            end
            total++;
            if (Read_Data_2 !== e.rd2) begin
                bad++;
                $display("FAIL %s rd2: got %b expected %b", e.tag, Read_Data_2, e.rd2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst_now        = 1'b0;
        prev_we        = 1'b0;
        prev_wa        = 0;
        prev_wd        = 0;
        reset          = 1'b0;
        Write_Enable   = 1'b0;
        Write_Address  = '0;
        Write_Data     = '0;
        Read_Address_1 = '0;
        Read_Address_2 = '0;

        // Writes attempted under reset must not stick.
        cycle(1, 0, 3, 0, 1, 0, 0, "reset_hold_a");
        cycle(1, 1, 2, 0, 1, 0, 0, "reset_hold_b");
        cycle(0, 0, 0, 0, 1, 1, 0, "reset_release");
        cycle(1, 0, 1, 0, 1, 1, 0, "write0_pre");
        cycle(1, 1, 3, 0, 1, 1, 0, "write1_pre");
        cycle(0, 1, 0, 0, 1, 1, 0, "write_off");
        cycle(0, 1, 0, 0, 1, 1, 0, "write_off_hold");
        cycle(0, 0, 0, 1, 1, 1, 0, "same_addr");
        cycle(0, 0, 0, 1, 1, 1, 1, "mid_reset");
        cycle(0, 0, 0, 0, 1, 1, 0, "after_mid_reset");
        cycle(1, 0, 1, 0, 1, 1, 0, "reload0");
        cycle(1, 0, 2, 0, 1, 1, 0, "bypass_pre");
        cycle(0, 0, 0, 0, 0, 1, 0, "bypass_post");

        for (int n = 0; n < 300; n++) begin
            bit rv;
            bit mr;
            rv = ($urandom_range(0, 19) != 0);
            mr = rv && ($urandom_range(0, 29) == 0);
            cycle($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 3),
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), rv, mr, "random");
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
